// File: rtl/ripple_mon_pkg.sv
// ripple_mon_pkg: shared types and constants for the ripple counter monitor.
// Contents: FSM state enum, counting-direction constants, filter length bound.
package ripple_mon_pkg;
  typedef enum logic {ACQUIRE, TRACK} state_e;
  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP = 1'b1;
  localparam int STABLE_MAX = 15;
endpackage

// File: rtl/sync_filter.sv
// sync_filter: 2-flop synchronizer plus stability filter for a ripple counter bus.
// Ports: CLK/Reset (async, active-high); a_i raw asynchronous counter bits;
//        accept_o one-cycle pulse when a value has been stable STABLE_CYCLES samples;
//        cand_o the accepted candidate, valid while accept_o is high.
module sync_filter import ripple_mon_pkg::*; #(
  parameter int N_BITS = 3,
  parameter int STABLE_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [N_BITS-1:0] a_i,
  output logic              accept_o,
  output logic [N_BITS-1:0] cand_o
);
  localparam int S = (STABLE_CYCLES < 1) ? 1 : (STABLE_CYCLES > STABLE_MAX) ? STABLE_MAX : STABLE_CYCLES;
  localparam logic [3:0] S4 = 4'(S);
  logic [N_BITS-1:0] sync1_q, sync2_q;
  logic [3:0] cnt_q, cnt_d;
  logic accept_q, accept_d, same;
  // sync2 doubles as the candidate register: the run is judged on the value
  // sync2 is loading, and accept is registered so it lines up with cand_o.
  always_comb begin
    same = sync1_q == sync2_q;
    cnt_d = !same ? 4'd1 : (cnt_q == S4) ? cnt_q : cnt_q + 4'd1;
    accept_d = (cnt_d == S4) && (cnt_q != S4 || !same);
  end
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q <= '0;
      accept_q <= 1'b0;
    end else begin
      sync1_q <= a_i;
      sync2_q <= sync1_q;
      cnt_q <= cnt_d;
      accept_q <= accept_d;
    end
  end
  assign accept_o = accept_q;
  assign cand_o = sync2_q;
endmodule

// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor: tracks a filtered ripple counter value and extends it to a wide event count.
// Ports: CLK/Reset (async, active-high); A raw counter bits; Clear sync clear of ExtCount/Skip;
//        Value last accepted code; ExtCount accumulated steps; Valid first value acquired;
//        Step pulse per accepted change; Wrap pulse on terminal-code crossing; Skip sticky non-unit move.
module ripple_count_monitor
  import ripple_mon_pkg::state_e, ripple_mon_pkg::ACQUIRE, ripple_mon_pkg::TRACK, ripple_mon_pkg::DIR_DOWN;
#(
  parameter int N_BITS = 3,
  parameter int EXT_WIDTH = 8,
  parameter bit DIR_UP = 1'b1,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic [N_BITS-1:0]    A,
  input  logic                 Clear,
  output logic [N_BITS-1:0]    Value,
  output logic [EXT_WIDTH-1:0] ExtCount,
  output logic                 Valid,
  output logic                 Step,
  output logic                 Wrap,
  output logic                 Skip
);
  localparam bit UP = DIR_UP != DIR_DOWN;
  state_e state_q, state_d;
  logic [N_BITS-1:0] value_q, value_d, cand, delta;
  logic [EXT_WIDTH-1:0] ext_q, ext_d;
  logic valid_q, valid_d, step_q, step_d, wrap_q, wrap_d, skip_q, skip_d, accept, moved;
  sync_filter #(.N_BITS(N_BITS), .STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .CLK(CLK),
    .Reset(Reset),
    .a_i(A),
    .accept_o(accept),
    .cand_o(cand)
  );
  // delta is taken modulo 2^N_BITS, so a terminal-code crossing still reads as 1.
  always_comb begin
    moved = accept && state_q == TRACK && cand != value_q;
    delta = UP ? cand - value_q : value_q - cand;
    state_d = accept ? TRACK : state_q;
    value_d = accept ? cand : value_q;
    valid_d = valid_q | accept;
    step_d = moved;
    wrap_d = moved && (UP ? value_q > cand : value_q < cand);
    ext_d = Clear ? '0 : moved ? ext_q + EXT_WIDTH'(delta) : ext_q;
    skip_d = Clear ? 1'b0 : skip_q | (moved && delta != N_BITS'(1));
  end
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= ACQUIRE;
      value_q <= '0;
      ext_q <= '0;
      valid_q <= 1'b0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      skip_q <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      ext_q <= ext_d;
      valid_q <= valid_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
      skip_q <= skip_d;
    end
  end
  assign Value = value_q;
  assign ExtCount = ext_q;
  assign Valid = valid_q;
  assign Step = step_q;
  assign Wrap = wrap_q;
  assign Skip = skip_q;
endmodule
